riscv_data_mem: RTL and testbench

Data-memory responder for the CPU core's data_mem initiator port (ce/we/addr/wdata out, rdata in). It is a single-port, word-organised RAM with a synchronous read, so load data appears exactly one cycle after the address, in the core's WB stage. After reset it zero-fills itself with a sequential clear FSM. It flags out-of-range accesses and optionally counts accesses for the bench.

---
 rtl/riscv_data_mem.sv | 165 ++++++++++++++++
 tb/tb_riscv_data_mem.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_data_mem.sv
// rtl/riscv_data_mem.sv - word-organised data RAM responder with clear-after-reset FSM
// Optional access counters are built only when RISCV_DMEM_STATS_EN is defined.
module riscv_data_mem #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned CLR_EN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        busy_o,
   output logic        err_o,
   output logic [31:0] rd_cnt_o,
   output logic [31:0] wr_cnt_o
);

   localparam int unsigned       DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] CNT_LAST = '1;

   typedef enum logic {ST_CLEAR, ST_READY} state_e;
   localparam state_e RST_STATE = (CLR_EN != 0) ? ST_CLEAR : ST_READY;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

   logic [ADDR_W-1:0] word_idx;
   logic              in_range;
   logic              unused_addr;

   logic              clearing;
   logic              rd_ok;
   logic              wr_ok;
   logic              oor;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem [DEPTH];

   logic [31:0]       data_q, data_d;
   logic              err_q, err_d;

   // Byte lanes are not supported; the low address bits carry no meaning.
   assign word_idx    = addr_i[ADDR_W+1:2];
   assign in_range    = (addr_i[31:ADDR_W+2] == '0);
   assign unused_addr = ^addr_i[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RST_STATE;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CNT_LAST) begin
               state_d = ST_READY;
            end
         end
         default: begin
            state_d = ST_READY;
         end
      endcase
   end

   always_comb begin
      clearing = 1'b0;
      rd_ok    = 1'b0;
      wr_ok    = 1'b0;
      oor      = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clearing = 1'b1;
         end
         default: begin
            rd_ok = ce_i & ~we_i & in_range;
            wr_ok = ce_i & we_i & in_range;
            oor   = ce_i & ~in_range;
         end
      endcase
   end

   assign busy_o = clearing;

   // The clear sweep and core stores share the single write port.
   always_comb begin
      mem_we    = clearing | wr_ok;
      mem_addr  = clearing ? clr_cnt_q : word_idx;
      mem_wdata = clearing ? 32'd0 : data_i;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   always_comb begin
      data_d = data_q;
      err_d  = oor;
      if (rd_ok) begin
         data_d = mem[word_idx];
      end else if (oor && !we_i) begin
         data_d = 32'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         err_q  <= err_d;
      end
   end

   assign data_o = data_q;
   assign err_o  = err_q;

`ifdef RISCV_DMEM_STATS_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;

   // Saturate rather than wrap so a long run never reports a small count.
   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (rd_ok && (rd_cnt_q != 32'hFFFF_FFFF)) begin
         rd_cnt_d = rd_cnt_q + 32'd1;
      end
      if (wr_ok && (wr_cnt_q != 32'hFFFF_FFFF)) begin
         wr_cnt_d = wr_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign rd_cnt_o = rd_cnt_q;
   assign wr_cnt_o = wr_cnt_q;
`else
   assign rd_cnt_o = 32'd0;
   assign wr_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_data_mem.sv
// tb/tb_riscv_data_mem.sv - scoreboard bench for riscv_data_mem, ADDR_W=4
// Counter expectations follow RISCV_DMEM_STATS_EN as defined for the build.
module tb_riscv_data_mem;

   localparam int unsigned AW = 4;
   localparam int unsigned NW = 16;
`ifdef RISCV_DMEM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        ce_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        busy_o;
   logic        err_o;
   logic [31:0] rd_cnt_o;
   logic [31:0] wr_cnt_o;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } sb_t;

   sb_t         sb_q[$];
   logic [31:0] model_mem [NW];
   logic [31:0] exp_hold;
   int unsigned model_rd;
   int unsigned model_wr;
   int          checks;
   int          passed;

   riscv_data_mem #(
      .ADDR_W(AW),
      .CLR_EN(1)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ce_i    (ce_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .data_i  (data_i),
      .data_o  (data_o),
      .busy_o  (busy_o),
      .err_o   (err_o),
      .rd_cnt_o(rd_cnt_o),
      .wr_cnt_o(wr_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NW; i++) model_mem[i] = 32'd0;
      exp_hold = 32'd0;
      model_rd = 0;
      model_wr = 0;
      sb_q.delete();
   endtask

   // Drive one READY-state access; the expected result is queued before the edge.
   task automatic drive(input logic ce, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      sb_t         e;
      logic        inr;
      logic [3:0]  idx;
      inr    = (addr[31:6] == 26'd0);
      idx    = addr[5:2];
      e.err  = ce && !inr;
      e.data = exp_hold;
      if (ce && !we) begin
         e.data = inr ? model_mem[idx] : 32'd0;
         if (inr) model_rd++;
      end
      if (ce && we && inr) begin
         model_mem[idx] = wdata;
         model_wr++;
      end
      exp_hold = e.data;
      sb_q.push_back(e);
      ce_i   = ce;
      we_i   = we;
      addr_i = addr;
      data_i = wdata;
      @(posedge clk);
      #1;
      ce_i = 1'b0;
      we_i = 1'b0;
   endtask

   task automatic wait_clear(output int n, output bit bad);
      n   = 0;
      bad = 1'b0;
      while (busy_o === 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (busy_o === 1'b1 && (data_o !== 32'd0 || err_o !== 1'b0)) bad = 1'b1;
      end
   endtask

   task automatic do_reset();
      ce_i  = 1'b0;
      we_i  = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      int n;
      bit bad;
      ce_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy_o !== 1'b1 || data_o !== 32'd0 || err_o !== 1'b0 || rd_cnt_o !== 32'd0 || wr_cnt_o !== 32'd0)
         $display("FAIL reset_state busy=%b data=%h err=%b rd=%0d wr=%0d required busy=1 others 0",
                  busy_o, data_o, err_o, rd_cnt_o, wr_cnt_o);
      else passed++;
      rst_n = 1'b1;
      model_reset();
      wait_clear(n, bad);
      checks++;
      if (n != NW) $display("FAIL clear_len busy cycles=%0d required %0d", n, NW);
      else passed++;
      checks++;
      if (bad) $display("FAIL clear_quiet data_o/err_o changed during clear, required 0");
      else passed++;
   endtask

   task automatic test_clear_zero();
      sb_t e;
      for (int i = 0; i < NW; i++) begin
         drive(1'b1, 1'b0, 32'(i * 4), 32'd0);
         e = sb_q.pop_front();
         checks++;
         if (data_o !== e.data || err_o !== e.err)
            $display("FAIL clear_zero[%0d] data=%h err=%b required %h %b", i, data_o, err_o, e.data, e.err);
         else passed++;
      end
   endtask

   task automatic test_store_load();
      sb_t e;
      drive(1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
      e = sb_q.pop_front();
      checks++;
      if (data_o !== e.data || err_o !== e.err)
         $display("FAIL store_hold data=%h err=%b required %h %b", data_o, err_o, e.data, e.err);
      else passed++;
      drive(1'b1, 1'b0, 32'h0000_0008, 32'd0);
      e = sb_q.pop_front();
      checks++;
      if (data_o !== e.data || data_o !== 32'hDEAD_BEEF)
         $display("FAIL load_8 data=%h required %h", data_o, e.data);
      else passed++;
      drive(1'b1, 1'b0, 32'h0000_0004, 32'd0);
      e = sb_q.pop_front();
      checks++;
      if (data_o !== e.data) $display("FAIL load_4 data=%h required %h", data_o, e.data);
      else passed++;
      drive(1'b1, 1'b0, 32'h0000_000B, 32'd0);
      e = sb_q.pop_front();
      checks++;
      if (data_o !== e.data || err_o !== e.err)
         $display("FAIL load_b data=%h err=%b required %h %b", data_o, err_o, e.data, e.err);
      else passed++;
      drive(1'b0, 1'b0, 32'h0000_0000, 32'd0);
      e = sb_q.pop_front();
      checks++;
      if (data_o !== e.data) $display("FAIL idle_hold data=%h required %h", data_o, e.data);
      else passed++;
   endtask

   task automatic test_out_of_range();
      sb_t e;
      drive(1'b1, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF);
      e = sb_q.pop_front();
      checks++;
      if (data_o !== e.data || err_o !== e.err)
         $display("FAIL oor_store data=%h err=%b required %h %b", data_o, err_o, e.data, e.err);
      else passed++;
      drive(1'b1, 1'b0, 32'h0000_0100, 32'd0);
      e = sb_q.pop_front();
      checks++;
      if (data_o !== e.data || err_o !== e.err)
         $display("FAIL oor_load data=%h err=%b required %h %b", data_o, err_o, e.data, e.err);
      else passed++;
      drive(1'b0, 1'b0, 32'h0000_0000, 32'd0);
      e = sb_q.pop_front();
      checks++;
      if (err_o !== e.err || data_o !== e.data)
         $display("FAIL oor_pulse err=%b data=%h required %b %h", err_o, data_o, e.err, e.data);
      else passed++;
      drive(1'b1, 1'b0, 32'h8000_0008, 32'd0);
      e = sb_q.pop_front();
      checks++;
      if (data_o !== e.data || err_o !== e.err)
         $display("FAIL oor_high data=%h err=%b required %h %b", data_o, err_o, e.data, e.err);
      else passed++;
      for (int i = 0; i < NW; i++) begin
         drive(1'b1, 1'b0, 32'(i * 4), 32'd0);
         e = sb_q.pop_front();
         checks++;
         if (data_o !== e.data || err_o !== e.err)
            $display("FAIL oor_untouched[%0d] data=%h err=%b required %h %b", i, data_o, err_o, e.data, e.err);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      sb_t         e;
      logic [31:0] a;
      logic [31:0] d;
      for (int i = 0; i < 8; i++) begin
         a = 32'($urandom_range(0, NW - 1) * 4);
         d = $urandom;
         drive(1'b1, 1'b1, a, d);
         e = sb_q.pop_front();
         checks++;
         if (data_o !== e.data) $display("FAIL b2b_store[%0d] data=%h required %h", i, data_o, e.data);
         else passed++;
         drive(1'b1, 1'b0, a, 32'd0);
         e = sb_q.pop_front();
         checks++;
         if (data_o !== e.data || data_o !== d)
            $display("FAIL b2b_load[%0d] data=%h required %h", i, data_o, e.data);
         else passed++;
      end
   endtask

   task automatic test_busy_store();
      sb_t e;
      int  n;
      bit  bad;
      do_reset();
      ce_i   = 1'b1;
      we_i   = 1'b1;
      addr_i = 32'h0000_0004;
      data_i = 32'h0000_1234;
      wait_clear(n, bad);
      ce_i = 1'b0;
      we_i = 1'b0;
      checks++;
      if (n != NW || bad) $display("FAIL busy_store_clear cycles=%0d quiet_violation=%b required %0d 0", n, bad, NW);
      else passed++;
      checks++;
      if (wr_cnt_o !== 32'd0) $display("FAIL busy_store_count wr_cnt=%0d required 0", wr_cnt_o);
      else passed++;
      drive(1'b1, 1'b0, 32'h0000_0004, 32'd0);
      e = sb_q.pop_front();
      checks++;
      if (data_o !== e.data || data_o !== 32'd0) $display("FAIL busy_store_dropped data=%h required %h", data_o, e.data);
      else passed++;
   endtask

   task automatic test_reset_midclear();
      int n;
      bit bad;
      do_reset();
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #2;
      checks++;
      if (busy_o !== 1'b1 || data_o !== 32'd0) $display("FAIL midclear_rst busy=%b data=%h required 1 0", busy_o, data_o);
      else passed++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      wait_clear(n, bad);
      checks++;
      if (n != NW) $display("FAIL midclear_len busy cycles=%0d required %0d", n, NW);
      else passed++;
      checks++;
      if (bad) $display("FAIL midclear_quiet data_o/err_o changed during clear, required 0");
      else passed++;
   endtask

   task automatic test_stats();
      sb_t         e;
      logic [31:0] exp_rd;
      logic [31:0] exp_wr;
      drive(1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_0001);
      drive(1'b1, 1'b0, 32'h0000_0010, 32'd0);
      drive(1'b1, 1'b1, 32'h0000_0014, 32'hA5A5_0002);
      drive(1'b1, 1'b0, 32'h0000_0014, 32'd0);
      drive(1'b1, 1'b0, 32'h0000_0200, 32'd0);
      drive(1'b1, 1'b0, 32'h0000_0000, 32'd0);
      while (sb_q.size() > 1) e = sb_q.pop_front();
      e = sb_q.pop_front();
      checks++;
      if (data_o !== e.data) $display("FAIL stats_last_load data=%h required %h", data_o, e.data);
      else passed++;
      exp_rd = STATS ? 32'(model_rd) : 32'd0;
      exp_wr = STATS ? 32'(model_wr) : 32'd0;
      checks++;
      if (rd_cnt_o !== exp_rd) $display("FAIL stats_rd rd_cnt=%0d required %0d", rd_cnt_o, exp_rd);
      else passed++;
      checks++;
      if (wr_cnt_o !== exp_wr) $display("FAIL stats_wr wr_cnt=%0d required %0d", wr_cnt_o, exp_wr);
      else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      rst_n  = 1'b0;
      ce_i   = 1'b0;
      we_i   = 1'b0;
      addr_i = '0;
      data_i = '0;
      model_reset();
      test_reset();
      test_clear_zero();
      test_store_load();
      test_out_of_range();
      test_back_to_back();
      test_busy_store();
      test_reset_midclear();
      test_stats();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
